ifu_pipelined: RTL and testbench

//  Parametrised instruction fetch unit for the pipelined Avalon ibus. It keeps up to
//  MAX_OUTSTANDING reads in flight and pairs each readdatavalid response with its request pc.

---
 rtl/core_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/ifu_pipelined.sv | 132 +++++++++++++
 tb/tb_ifu_pipelined.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the instruction fetch path: Avalon ibus request/response and IFQ entries.
package core_pkg;

  localparam int PC_WIDTH = 32;

  typedef struct packed {
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic        waitrequest;
    logic [31:0] readdata;
  } avalon_resp_t;

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
  } ifq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and synchronous clear.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  // A depth-1 FIFO still needs one index bit; alternating two slots keeps count correct.
  localparam int IW = (AW > 0) ? AW : 1;
  localparam logic [AW:0] ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [0:(2**IW)-1];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;

  assign count_o = wptr_q - rptr_q;
  assign empty_o = (count_o == '0);
  assign rdata_o = mem_q[rptr_q[IW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_i)            wptr_d = wptr_q + ONE;
      if (pop_i && !empty_o) rptr_d = rptr_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[IW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ifu_pipelined.sv
// Pipelined Avalon instruction fetch: credit-limited issue, pc tag FIFO, flush by response counting.
module ifu_pipelined
  import core_pkg::*;
#(
  parameter int                  IFQ_DEPTH       = 4,
  parameter int                  MAX_OUTSTANDING = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_flush,
  input  logic                branch_take,
  input  logic [PC_WIDTH-1:0] branch_pc,
  input  logic                trap_take,
  input  logic [PC_WIDTH-1:0] trap_pc,
  output logic [31:0]         instruction,
  output logic [31:0]         instruction_pc,
  output logic                instruction_valid,
  input  logic                instruction_ready,
  output avalon_req_t         ibus_avalon_req,
  input  avalon_resp_t        ibus_avalon_resp,
  input  logic                ibus_readdatavalid
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int QW = $clog2(IFQ_DEPTH) + 1;

  logic [PC_WIDTH-1:0] pc_q, pc_d, pending_pc_q, pending_pc_d, tag, redirect_pc;
  logic                redirect_pending_q, redirect_pending_d;
  logic [OW-1:0]       outstanding, outstanding_next, discard_q, discard_d;
  logic [QW-1:0]       ifq_count;
  logic                read, accept, redirect, wait_req;
  logic                tag_empty, resp_pop, resp_drop, ifq_push, ifq_pop, ifq_empty;
  ifq_entry_t          ifq_wdata, ifq_head;

  assign wait_req = ibus_avalon_resp.waitrequest;

  // Issue only when a returning response is guaranteed a free IFQ slot.
  assign read = ~rst & (outstanding < OW'(MAX_OUTSTANDING))
              & ((32'(ifq_count) + 32'(outstanding)) < 32'(IFQ_DEPTH));
  assign accept = read & ~wait_req;

  assign resp_pop  = ibus_readdatavalid & ~tag_empty;
  assign resp_drop = resp_pop & (ifu_flush | (discard_q != '0));
  assign ifq_push  = resp_pop & ~resp_drop;
  assign ifq_pop   = instruction_valid & instruction_ready;

  assign outstanding_next = outstanding + OW'(accept) - OW'(resp_pop);
  assign redirect         = trap_take | branch_take;
  assign redirect_pc      = trap_take ? trap_pc : branch_pc;

  always_comb begin
    pc_d               = pc_q;
    pending_pc_d       = pending_pc_q;
    redirect_pending_d = redirect_pending_q;
    discard_d          = discard_q;
    // A redirect during waitrequest is parked so the committed address stays on the bus.
    if (redirect) begin
      if (wait_req) begin
        pending_pc_d       = redirect_pc;
        redirect_pending_d = 1'b1;
      end else begin
        pc_d               = redirect_pc;
        redirect_pending_d = 1'b0;
      end
    end else if (redirect_pending_q && !wait_req) begin
      pc_d               = pending_pc_q;
      redirect_pending_d = 1'b0;
    end else if (accept) begin
      pc_d = pc_q + 32'd4;
    end
    if (ifu_flush)      discard_d = outstanding_next;
    else if (resp_drop) discard_d = discard_q - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q               <= RESET_PC;
      redirect_pending_q <= 1'b0;
      discard_q          <= '0;
    end else begin
      pc_q               <= pc_d;
      redirect_pending_q <= redirect_pending_d;
      discard_q          <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    pending_pc_q <= pending_pc_d;
  end

  sync_fifo #(.WIDTH(PC_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (1'b0),
    .push_i  (accept),
    .wdata_i (pc_q),
    .pop_i   (resp_pop),
    .rdata_o (tag),
    .count_o (outstanding),
    .empty_o (tag_empty)
  );

  assign ifq_wdata = '{instr: ibus_avalon_resp.readdata, pc: tag};

  sync_fifo #(.WIDTH($bits(ifq_entry_t)), .DEPTH(IFQ_DEPTH)) u_ifq (
    .clk     (clk),
    .rst     (rst),
    .clear_i (ifu_flush),
    .push_i  (ifq_push),
    .wdata_i (ifq_wdata),
    .pop_i   (ifq_pop),
    .rdata_o (ifq_head),
    .count_o (ifq_count),
    .empty_o (ifq_empty)
  );

  assign instruction       = ifq_head.instr;
  assign instruction_pc    = ifq_head.pc;
  assign instruction_valid = ~ifq_empty;

  always_comb begin
    ibus_avalon_req             = '0;
    ibus_avalon_req.address     = pc_q;
    ibus_avalon_req.read        = read;
    ibus_avalon_req.byte_enable = 4'hF;
  end

  a_rdv_expected: assert property (@(posedge clk) disable iff (rst)
    ibus_readdatavalid |-> !tag_empty);

endmodule

// File: tb/tb_ifu_pipelined.sv
// Directed and randomized bench for ifu_pipelined with a transaction-level fetch/deliver model.
module tb_ifu_pipelined;
  import core_pkg::*;

  localparam int          IFQ_DEPTH = 4;
  localparam int          MAX_OUT   = 2;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic        clk, rst, ifu_flush, branch_take, trap_take, instruction_ready;
  logic [31:0] branch_pc, trap_pc, instruction, instruction_pc;
  logic        instruction_valid, rdv;
  avalon_req_t  req;
  avalon_resp_t resp;

  ifu_pipelined #(.IFQ_DEPTH(IFQ_DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk                (clk),
    .rst                (rst),
    .ifu_flush          (ifu_flush),
    .branch_take        (branch_take),
    .branch_pc          (branch_pc),
    .trap_take          (trap_take),
    .trap_pc            (trap_pc),
    .instruction        (instruction),
    .instruction_pc     (instruction_pc),
    .instruction_valid  (instruction_valid),
    .instruction_ready  (instruction_ready),
    .ibus_avalon_req    (req),
    .ibus_avalon_resp   (resp),
    .ibus_readdatavalid (rdv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  rsp_t        slq[$];       // reads accepted by the memory, awaiting response
  ent_t        expq[$];      // expected IFQ contents
  logic [31:0] acc_log[$];
  logic [31:0] del_log[$];
  logic [31:0] exp_next, pend_pc;
  logic        pend, hold;
  int          disc, cyc, lat;
  int          n_cmp, n_mis;
  logic        s_valid, s_read;
  logic [31:0] s_addr;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h5A5A};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        s_acc, s_rdv, s_flush, s_rst, s_redir, s_wr, s_pop;
    logic [31:0] s_tgt;
    rsp_t        r;
    #4;
    s_rst   = rst;
    s_wr    = resp.waitrequest;
    s_rdv   = rdv;
    s_flush = ifu_flush;
    s_redir = trap_take | branch_take;
    s_tgt   = trap_take ? trap_pc : branch_pc;
    s_valid = instruction_valid;
    s_read  = req.read;
    s_addr  = req.address;
    s_acc   = req.read & ~s_wr;
    s_pop   = instruction_valid & instruction_ready;
    chk("valid", 32'(instruction_valid), 32'(expq.size() != 0));
    chk("read", 32'(req.read),
        32'(!rst && (slq.size() < MAX_OUT) && ((expq.size() + slq.size()) < IFQ_DEPTH)));
    chk("fixed_fields", {req.writedata[27:0], req.write, req.byte_enable[2:0]}, 32'h7);
    if (s_acc) begin
      chk("fetch_addr", req.address, exp_next);
      acc_log.push_back(req.address);
    end
    if (s_pop && expq.size() > 0) begin
      chk("head_pc", instruction_pc, expq[0].pc);
      chk("head_instr", instruction, expq[0].instr);
      del_log.push_back(instruction_pc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (s_rst) begin
      slq.delete();
      expq.delete();
      disc     = 0;
      pend     = 1'b0;
      exp_next = RESET_PC;
    end else begin
      if (s_pop && expq.size() > 0) void'(expq.pop_front());
      if (s_rdv && slq.size() > 0) begin
        r = slq.pop_front();
        if (s_flush || disc > 0) begin
          if (!s_flush) disc--;
        end else begin
          expq.push_back('{memfn(r.addr), r.addr});
        end
      end
      if (s_acc) begin
        slq.push_back('{s_addr, cyc + lat});
        exp_next = exp_next + 32'd4;
      end
      if (s_flush) begin
        expq.delete();
        disc = slq.size();
      end
      if (s_redir) begin
        if (s_wr) begin
          pend    = 1'b1;
          pend_pc = s_tgt;
        end else begin
          exp_next = s_tgt;
          pend     = 1'b0;
        end
      end else if (pend && !s_wr) begin
        exp_next = pend_pc;
        pend     = 1'b0;
      end
    end
    rdv = !rst && !hold && (slq.size() > 0) && (slq[0].due <= cyc + 1);
    resp.readdata = rdv ? memfn(slq[0].addr) : 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1; hold = 1'b0; ifu_flush = 1'b0; branch_take = 1'b0; trap_take = 1'b0;
    resp.waitrequest = 1'b0; instruction_ready = 1'b0; lat = 1;
    tick();
    tick();
    chk("rst_valid", 32'(s_valid), 32'h0);
    chk("rst_read", 32'(s_read), 32'h0);
    rst = 1'b0;
    acc_log.delete();
    del_log.delete();
  endtask

  // Brings the unit to two entries queued and two reads held in flight at 0x8/0xC.
  task automatic fill_half_and_hold();
    instruction_ready = 1'b0;
    for (int k = 0; k < 20 && acc_log.size() < 2; k++) tick();
    resp.waitrequest = 1'b1;
    repeat (3) tick();
    hold = 1'b1;
    resp.waitrequest = 1'b0;
    for (int k = 0; k < 20 && acc_log.size() < 4; k++) tick();
    resp.waitrequest = 1'b1;
    chk("setup_accepts", 32'(acc_log.size()), 32'd4);
  endtask

  initial begin
    int n;
    n_cmp = 0; n_mis = 0; cyc = 0; disc = 0; pend = 1'b0; pend_pc = '0;
    exp_next = RESET_PC; rdv = 1'b0; resp = '0; branch_pc = '0; trap_pc = '0;

    // Zero-wait streaming.
    do_reset();
    instruction_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t1_valid", 32'(s_valid), 32'(i >= 2));
      if (i >= 2) chk("t1_pc", del_log.size() > 0 ? del_log[del_log.size()-1] : 32'hDEAD_BEEF,
                      32'((i - 2) * 4));
    end

    // Decode stalled: credit limits the number of reads.
    do_reset();
    repeat (12) tick();
    chk("t2_accepts", 32'(acc_log.size()), 32'd4);
    chk("t2_read_off", 32'(s_read), 32'h0);
    instruction_ready = 1'b1;
    for (int k = 0; k < 20 && del_log.size() < 4; k++) tick();
    for (int i = 0; i < 4; i++)
      chk("t2_order", i < del_log.size() ? del_log[i] : 32'hDEAD_BEEF, 32'(i * 4));

    // Flush with reads in flight, plus branch.
    do_reset();
    fill_half_and_hold();
    ifu_flush = 1'b1; branch_take = 1'b1; branch_pc = 32'h100; resp.waitrequest = 1'b0;
    tick();
    ifu_flush = 1'b0; branch_take = 1'b0; hold = 1'b0; instruction_ready = 1'b1;
    del_log.delete();
    for (int k = 0; k < 30 && del_log.size() == 0; k++) tick();
    chk("t3_first_pc", del_log.size() > 0 ? del_log[0] : 32'hDEAD_BEEF, 32'h100);

    // Trap while the bus stalls the read at 0x10.
    do_reset();
    instruction_ready = 1'b1;
    for (int k = 0; k < 20 && acc_log.size() < 4; k++) tick();
    resp.waitrequest = 1'b1;
    tick();
    chk("t4_addr", s_addr, 32'h10);
    chk("t4_read", 32'(s_read), 32'h1);
    trap_take = 1'b1; trap_pc = 32'h80;
    tick();
    trap_take = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold", s_addr, 32'h10);
    end
    resp.waitrequest = 1'b0;
    for (int k = 0; k < 20 && acc_log.size() < 6; k++) tick();
    chk("t4_committed", acc_log.size() > 4 ? acc_log[4] : 32'hDEAD_BEEF, 32'h10);
    chk("t4_target", acc_log.size() > 5 ? acc_log[5] : 32'hDEAD_BEEF, 32'h80);

    // Trap and branch together.
    trap_take = 1'b1; trap_pc = 32'h80; branch_take = 1'b1; branch_pc = 32'h200;
    tick();
    trap_take = 1'b0; branch_take = 1'b0;
    n = acc_log.size();
    for (int k = 0; k < 20 && acc_log.size() <= n; k++) tick();
    chk("t5_trap_wins", acc_log.size() > n ? acc_log[n] : 32'hDEAD_BEEF, 32'h80);

    // Reset in the middle of traffic.
    do_reset();
    fill_half_and_hold();
    rst = 1'b1;
    tick();
    tick();
    chk("t6_valid", 32'(s_valid), 32'h0);
    chk("t6_read", 32'(s_read), 32'h0);
    rst = 1'b0; hold = 1'b0; resp.waitrequest = 1'b0;
    tick();
    chk("t6_addr", s_addr, RESET_PC);
    chk("t6_read_on", 32'(s_read), 32'h1);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      instruction_ready = ($urandom_range(0, 9) < 7);
      resp.waitrequest  = ($urandom_range(0, 9) < 3);
      ifu_flush         = ($urandom_range(0, 99) < 3);
      trap_take         = ($urandom_range(0, 99) < 2);
      branch_take       = ($urandom_range(0, 99) < 4);
      trap_pc           = 32'($urandom_range(0, 1023)) << 2;
      branch_pc         = 32'($urandom_range(0, 1023)) << 2;
      lat               = $urandom_range(1, 3);
      tick();
    end
    ifu_flush = 1'b0; trap_take = 1'b0; branch_take = 1'b0;
    resp.waitrequest = 1'b0; instruction_ready = 1'b1; lat = 1;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
